// File: rtl/config_stream_loader_if.sv
// Host-side pair handshake and config-bus outputs of the stream loader.
// Latency: none (wires only).
// Backpressure: host_ready_out is driven by the loader; the config bus has no ready.
interface config_stream_loader_if;
    logic        host_valid_in;
    logic        host_ready_out;
    logic [31:0] host_addr_in;
    logic [31:0] host_data_in;
    logic        host_last_in;
    logic [31:0] config_addr_out;
    logic [31:0] config_data_out;
    logic        config_valid_out;

    modport master (
        output host_valid_in, host_addr_in, host_data_in, host_last_in,
        input  host_ready_out, config_addr_out, config_data_out, config_valid_out
    );

    modport slave (
        input  host_valid_in, host_addr_in, host_data_in, host_last_in,
        output host_ready_out, config_addr_out, config_data_out, config_valid_out
    );
endinterface

// File: rtl/config_stream_loader.sv
// Buffers host addr/data pairs and replays each on the CGRA config bus for HOLD cycles.
// Latency: 1 cycle from acceptance into an empty FIFO to the word appearing on the bus.
// Backpressure: host_ready_out low when the FIFO is full or once the last pair is taken.
module config_stream_loader #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 1
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    config_stream_loader_if.slave   bus,
    input  logic                    clear_in,
    output logic                    config_done_out,
    output logic                    pad_enable_out,
    output logic [15:0]             word_count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

    typedef struct packed {
        logic        last;
        logic [31:0] addr;
        logic [31:0] data;
    } pair_t;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t      state, state_d;
    pair_t       mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, push, pop;
    logic        out_vld, out_last;
    logic [31:0] out_addr, out_data;
    logic [3:0]  hold_cnt;
    logic        issuer_free, hold_end, clear_done;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bus.host_ready_out = !full && (state == IDLE || state == LOAD);
    assign push        = bus.host_valid_in && bus.host_ready_out;
    assign hold_end    = out_vld && (hold_cnt == 4'd0);
    assign issuer_free = !out_vld || (hold_cnt == 4'd0);
    assign pop         = issuer_free && !empty;
    assign clear_done  = (state == DONE) && clear_in;

    assign bus.config_valid_out = out_vld;
    assign bus.config_addr_out  = out_addr;
    assign bus.config_data_out  = out_data;
    assign config_done_out      = (state == DONE);

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{last: bus.host_last_in,
                                     addr: bus.host_addr_in,
                                     data: bus.host_data_in};
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_done) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A new word loads on the same edge the previous hold ends, so holds abut.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            hold_cnt <= '0;
        end else if (pop) begin
            out_vld  <= 1'b1;
            out_last <= mem[rd_ptr[AW-1:0]].last;
            out_addr <= mem[rd_ptr[AW-1:0]].addr;
            out_data <= mem[rd_ptr[AW-1:0]].data;
            hold_cnt <= HOLD_M1;
        end else if (issuer_free) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            word_count_out <= '0;
        end else if (clear_done) begin
            word_count_out <= '0;
        end else if (pop && word_count_out != 16'hFFFF) begin
            word_count_out <= word_count_out + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state          <= IDLE;
            pad_enable_out <= 1'b0;
        end else begin
            state          <= state_d;
            pad_enable_out <= (state == DONE) && (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (push) state_d = bus.host_last_in ? DRAIN : LOAD;
            end
            LOAD: begin
                if (push && bus.host_last_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (hold_end && out_last) state_d = DONE;
            end
            DONE: begin
                if (clear_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench: HOLD=1 instance driven from a vector table, HOLD=3 instance by stream sequences.
module tb_config_stream_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clr1, clr3;
    logic        done1, pad1, done3, pad3;
    logic [15:0] cnt1, cnt3;

    config_stream_loader_if if1();
    config_stream_loader_if if3();

    config_stream_loader #(.DEPTH(4), .HOLD(1)) u1 (
        .clk_in(clk), .reset_in(rst_n), .bus(if1), .clear_in(clr1),
        .config_done_out(done1), .pad_enable_out(pad1), .word_count_out(cnt1)
    );

    config_stream_loader #(.DEPTH(4), .HOLD(3)) u3 (
        .clk_in(clk), .reset_in(rst_n), .bus(if3), .clear_in(clr3),
        .config_done_out(done3), .pad_enable_out(pad3), .word_count_out(cnt3)
    );

    typedef struct packed {
        logic        rdy;
        logic        vld;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        pad;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
        logic        clear;
        obs_t        exp;
    } vec_t;

    int checks = 0;
    int failures = 0;

    function automatic obs_t ob(logic rdy, logic vld, logic [31:0] a, logic [31:0] d,
                                logic done, logic pad, logic [15:0] cnt);
        obs_t o;
        o.rdy = rdy; o.vld = vld; o.addr = a; o.data = d;
        o.done = done; o.pad = pad; o.cnt = cnt;
        return o;
    endfunction

    function automatic vec_t mkv(logic v, logic [31:0] a, logic [31:0] d, logic l, logic c, obs_t e);
        vec_t r;
        r.valid = v; r.addr = a; r.data = d; r.last = l; r.clear = c; r.exp = e;
        return r;
    endfunction

    function automatic obs_t get1();
        return ob(if1.host_ready_out, if1.config_valid_out, if1.config_addr_out,
                  if1.config_data_out, done1, pad1, cnt1);
    endfunction

    function automatic obs_t get3();
        return ob(if3.host_ready_out, if3.config_valid_out, if3.config_addr_out,
                  if3.config_data_out, done3, pad3, cnt3);
    endfunction

    function automatic logic [31:0] addr_of(logic [31:0] base, int k);
        return base + 32'(k);
    endfunction

    function automatic logic [31:0] data_of(logic [31:0] base, int k);
        return (base << 4) ^ 32'h5A5A_0000 ^ 32'(k);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={rdy,vld,addr,data,done,pad,cnt}=%h required=%h", name, act, exp);
        end
    endtask

    // Streams n pairs into u3 with valid held high and checks every cycle against
    // the ideal back-to-back HOLD=3 timeline; abort_c >= 0 stops early after that cycle.
    task automatic run_stream(input int n, input logic [31:0] base, input int abort_c);
        int pushed;
        int k;
        int last_c;
        logic [11:0] rdy8;
        obs_t a, e;
        pushed = 0;
        last_c = 3 * n + 3;
        rdy8   = 12'b1001_0011_1111;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            if3.host_valid_in = (pushed < n);
            if3.host_addr_in  = addr_of(base, pushed);
            if3.host_data_in  = data_of(base, pushed);
            if3.host_last_in  = (pushed == n - 1);
            #1;
            a = get3();
            e = ob(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);
            if (n == 8) e.rdy = (c < 12) ? rdy8[c] : 1'b0;
            else        e.rdy = (c < n);
            if (c >= 2 && c <= 3 * n + 1) begin
                k = (c - 2) / 3;
                e.vld  = 1'b1;
                e.addr = addr_of(base, k);
                e.data = data_of(base, k);
            end
            if (c >= 2) e.cnt = 16'(((c - 2) / 3 + 1 < n) ? (c - 2) / 3 + 1 : n);
            e.done = (c >= 3 * n + 2);
            e.pad  = (c >= 3 * n + 3);
            check($sformatf("s%0d_c%0d", n, c), a, e);
            if (c == abort_c) begin
                if3.host_valid_in = 1'b0;
                return;
            end
            if (a.rdy && if3.host_valid_in) pushed++;
        end
        checks++;
        if (pushed != n) begin
            failures++;
            $display("FAIL s%0d_pushed actual=%0d required=%0d", n, pushed, n);
        end
    endtask

    task automatic clear3();
        @(negedge clk);
        clr3 = 1'b1;
        @(negedge clk);
        clr3 = 1'b0;
        #1;
        check("clear3", get3(), ob(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0));
    endtask

    vec_t tbl [12];

    initial begin
        rst_n = 1'b0;
        clr1 = 1'b0; clr3 = 1'b0;
        if1.host_valid_in = 1'b0; if1.host_addr_in = '0; if1.host_data_in = '0; if1.host_last_in = 1'b0;
        if3.host_valid_in = 1'b0; if3.host_addr_in = '0; if3.host_data_in = '0; if3.host_last_in = 1'b0;

        tbl[0]  = mkv(1, 32'h1,  32'h7,  1, 0, ob(1, 0, 32'h0,  32'h0,  0, 0, 16'd0));
        tbl[1]  = mkv(0, 32'h0,  32'h0,  0, 0, ob(0, 0, 32'h0,  32'h0,  0, 0, 16'd0));
        tbl[2]  = mkv(0, 32'h0,  32'h0,  0, 0, ob(0, 1, 32'h1,  32'h7,  0, 0, 16'd1));
        tbl[3]  = mkv(0, 32'h0,  32'h0,  0, 0, ob(0, 0, 32'h0,  32'h0,  1, 0, 16'd1));
        tbl[4]  = mkv(0, 32'h0,  32'h0,  0, 1, ob(0, 0, 32'h0,  32'h0,  1, 1, 16'd1));
        tbl[5]  = mkv(1, 32'h10, 32'hAA, 0, 0, ob(1, 0, 32'h0,  32'h0,  0, 0, 16'd0));
        tbl[6]  = mkv(1, 32'h20, 32'hBB, 0, 1, ob(1, 0, 32'h0,  32'h0,  0, 0, 16'd0));
        tbl[7]  = mkv(1, 32'h30, 32'hCC, 1, 0, ob(1, 1, 32'h10, 32'hAA, 0, 0, 16'd1));
        tbl[8]  = mkv(0, 32'h0,  32'h0,  0, 0, ob(0, 1, 32'h20, 32'hBB, 0, 0, 16'd2));
        tbl[9]  = mkv(0, 32'h0,  32'h0,  0, 0, ob(0, 1, 32'h30, 32'hCC, 0, 0, 16'd3));
        tbl[10] = mkv(0, 32'h0,  32'h0,  0, 0, ob(0, 0, 32'h0,  32'h0,  1, 0, 16'd3));
        tbl[11] = mkv(0, 32'h0,  32'h0,  0, 0, ob(0, 0, 32'h0,  32'h0,  1, 1, 16'd3));

        #1;
        check("reset_u1", get1(), ob(1, 0, 32'h0, 32'h0, 0, 0, 16'd0));
        check("reset_u3", get3(), ob(1, 0, 32'h0, 32'h0, 0, 0, 16'd0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if1.host_valid_in = tbl[i].valid;
            if1.host_addr_in  = tbl[i].addr;
            if1.host_data_in  = tbl[i].data;
            if1.host_last_in  = tbl[i].last;
            clr1              = tbl[i].clear;
            #1;
            check($sformatf("vec%0d", i), get1(), tbl[i].exp);
        end
        @(negedge clk);
        if1.host_valid_in = 1'b0;
        clr1 = 1'b0;

        run_stream(6, 32'h0000_1000, -1);
        clear3();
        run_stream(8, 32'h0000_2000, -1);
        clear3();

        run_stream(4, 32'h0000_3000, 9);
        rst_n = 1'b0;
        #1;
        check("midreset_u3", get3(), ob(1, 0, 32'h0, 32'h0, 0, 0, 16'd0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_stream(2, 32'h0000_4000, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/config_stream_loader.md
CONFIG_STREAM_LOADER -- requirements
Module: config_stream_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 4: FIFO entries (address/data pairs), power of two, at least 2.
REQ-002 SHALL have parameter HOLD, default 1: cycles each config word is held on the output bus, 1..15.
REQ-003 SHALL have port clk_in, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_in, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port host_valid_in, input, 1: host presents a config pair.
REQ-006 SHALL have port host_ready_out, output, 1: loader accepts the pair this cycle.
REQ-007 SHALL have port host_addr_in, input, 32: config address.
REQ-008 SHALL have port host_data_in, input, 32: config data.
REQ-009 SHALL have port host_last_in, input, 1: marks the final pair of the bitstream.
REQ-010 SHALL have port clear_in, input, 1: synchronous return from DONE to IDLE.
REQ-011 SHALL have port config_addr_out, output, 32: address to the CGRA config bus.
REQ-012 SHALL have port config_data_out, output, 32: data to the CGRA config bus.
REQ-013 SHALL have port config_valid_out, output, 1: a config word is on the bus this cycle.
REQ-014 SHALL have port config_done_out, output, 1: all pairs issued.
REQ-015 SHALL have port pad_enable_out, output, 1: releases application pad inputs after configuration.
REQ-016 SHALL have port word_count_out, output, 16: number of pairs issued.

Function
REQ-017 SHALL transfer a pair only on a rising edge where host_valid_in and host_ready_out are both high.
REQ-018 SHALL drive host_ready_out as: FIFO not full, and state is IDLE or LOAD.
REQ-019 SHALL block acceptance while the FIFO is full, even if a pop occurs in the same cycle (no bypass).
REQ-020 SHALL store address, data and last flag together in a DEPTH-entry circular FIFO; read and write pointers wrap modulo DEPTH.
REQ-021 SHALL implement states IDLE, LOAD, DRAIN, DONE:
- IDLE->LOAD on a transfer without last.
- IDLE or LOAD->DRAIN on a transfer with last.
- DRAIN->DONE on the edge that ends the hold of the last-flagged word.
- DONE->IDLE on clear_in; clear_in is ignored in all other states.
REQ-022 SHALL pop the FIFO head when the issuer is free and the FIFO is non-empty.
REQ-023 SHALL register the popped pair onto config_addr_out/config_data_out, with config_valid_out high, for exactly HOLD consecutive cycles.
REQ-024 SHALL give minimum latency of one cycle: a pair accepted at edge N into an empty FIFO with the issuer free is on the bus from edge N+1.
REQ-025 SHALL issue back-to-back words with no idle cycle between holds when the FIFO is non-empty.
REQ-026 SHALL drive config_addr_out and config_data_out to 0 whenever config_valid_out is low.
REQ-027 SHALL increment word_count_out once per issued pair, at the start of its hold, saturating at 0xFFFF.
REQ-028 SHALL assert config_done_out in DONE only.
REQ-029 SHALL assert pad_enable_out starting one cycle after config_done_out first rises, and deassert both on leaving DONE.
REQ-030 SHALL, on clear_in in DONE, zero word_count_out and empty the FIFO.

Reset
REQ-031 SHALL, while reset_in is low, force: state IDLE, FIFO empty, host_ready_out 1, config_valid_out 0, config_addr_out 0, config_data_out 0, config_done_out 0, pad_enable_out 0, word_count_out 0.
REQ-032 SHALL, when reset is asserted mid-stream, discard all buffered and in-hold pairs with no partial word issued after reset release.
REQ-033 SHALL allow the first transfer on the first rising edge after reset_in goes high.

Verification
REQ-034 SHALL be verified with a single pair (addr 0x00000001, data 0x00000007, last) accepted at edge N with HOLD=1 -> bus shows it in cycle N+1 only; config_done_out rises at N+2; pad_enable_out rises at N+3; word_count_out=1.
REQ-035 SHALL be verified with 6 pairs streamed continuously, DEPTH=4, sink always free, HOLD=3 -> host_ready_out drops while full; all 6 pairs are issued in order, each for 3 cycles, with no gaps; word_count_out=6.
REQ-036 SHALL be verified with simultaneous pop and push attempt while full -> push refused that cycle, accepted next cycle; pointers wrap with no loss or duplication.
REQ-037 SHALL be verified with reset_in pulsed low during the 3rd word's hold -> outputs zero immediately; after release, a new 2-pair stream issues correctly with word_count_out=2.
REQ-038 SHALL be verified with clear_in in DONE, then a new stream -> state returns to IDLE, word_count_out=0, and the new stream completes; clear_in asserted in LOAD has no effect.
